// File: rtl/riscv_lsu_pkg.sv
// Shared constants, state type and byte-lane helpers for the load-store unit.
package riscv_lsu_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned BE_W   = XLEN / 8;

  localparam logic [2:0] LDST_B  = 3'd0;
  localparam logic [2:0] LDST_H  = 3'd1;
  localparam logic [2:0] LDST_W  = 3'd2;
  localparam logic [2:0] LDST_BU = 3'd4;
  localparam logic [2:0] LDST_HU = 3'd5;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } lsu_state_t;

  // Byte enables from access width (funct3[1:0]) and address offset.
  function automatic logic [BE_W-1:0] lsu_be(input logic [2:0] size, input logic [1:0] off);
    logic [BE_W-1:0] be;
    case (size[1:0])
      2'd0:    be = 4'b0001 << off;
      2'd1:    be = 4'b0011 << {off[1], 1'b0};
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // Store data replicated across every lane it may land in.
  function automatic logic [XLEN-1:0] lsu_wd(input logic [2:0] size, input logic [XLEN-1:0] wd);
    logic [XLEN-1:0] res;
    case (size[1:0])
      2'd0:    res = {4{wd[7:0]}};
      2'd1:    res = {2{wd[15:0]}};
      default: res = wd;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/riscv_lsu_if.sv
// Data-memory request/response bus between the LSU (master) and memory (slave).
interface riscv_lsu_if;
  import riscv_lsu_pkg::*;

  logic            req;
  logic            we;
  logic [BE_W-1:0] be;
  logic [XLEN-1:0] addr;
  logic [XLEN-1:0] wd;
  logic [XLEN-1:0] rd;
  logic            ready;

  modport master (output req, we, be, addr, wd, input rd, ready);
  modport slave  (input req, we, be, addr, wd, output rd, ready);
endinterface

// File: rtl/riscv_lsu_rd_fmt.sv
// Extracts and extends the addressed byte/half of a loaded word.
module riscv_lsu_rd_fmt
  import riscv_lsu_pkg::*;
(
  input  logic [XLEN-1:0] word,
  input  logic [1:0]      off,
  input  logic [2:0]      size,
  output logic [XLEN-1:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = 8'(word >> {off, 3'b000});
    half_sel = off[1] ? word[31:16] : word[15:0];
    case (size)
      LDST_B:  result = {{24{byte_sel[7]}}, byte_sel};
      LDST_BU: result = {24'd0, byte_sel};
      LDST_H:  result = {{16{half_sel[15]}}, half_sel};
      LDST_HU: result = {16'd0, half_sel};
      LDST_W:  result = word;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/riscv_lsu.sv
// Load-store unit: one handshaked memory transaction per core access, core stalled until done.
module riscv_lsu
  import riscv_lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             core_req_i,
  input  logic             core_we_i,
  input  logic [2:0]       core_size_i,
  input  logic [XLEN-1:0]  core_addr_i,
  input  logic [XLEN-1:0]  core_wd_i,
  output logic [XLEN-1:0]  core_rd_o,
  output logic             core_stall_o,
  output logic             core_err_o,
  riscv_lsu_if.master      mem
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  lsu_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             we_q, we_d;
  logic [1:0]       off_q, off_d;
  logic [2:0]       size_q, size_d;
  logic [XLEN-1:0]  rdata_q, rdata_d;
  logic [XLEN-1:0]  fmt_res;

  logic illegal, misaligned, acc_err, timeout_hit;

  // Access legality on the live core inputs.
  always_comb begin
    illegal    = (core_size_i == 3'd3) || (core_size_i[2:1] == 2'b11) ||
                 (core_we_i && core_size_i[2]);
    misaligned = ((core_size_i[1:0] == 2'd1) && core_addr_i[0]) ||
                 ((core_size_i[1:0] == 2'd2) && (core_addr_i[1:0] != 2'b00));
    acc_err    = illegal || misaligned;
    timeout_hit = (TIMEOUT_CYCLES != 0) && (state_q == BUSY) &&
                  (cnt_q == CNT_W'(TIMEOUT_CYCLES));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      off_q   <= '0;
      size_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      we_q    <= we_d;
      off_q   <= off_d;
      size_q  <= size_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    we_d    = we_q;
    off_d   = off_q;
    size_d  = size_q;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (core_req_i) begin
          we_d   = core_we_i;
          off_d  = core_addr_i[1:0];
          size_d = core_size_i;
          if (acc_err) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else if (mem.ready) begin
            rdata_d = mem.rd;
            err_d   = 1'b0;
            state_d = DONE;
          end else begin
            cnt_d   = CNT_W'(1);
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        // Abort wins: the request is already withdrawn in the timeout cycle.
        if (timeout_hit) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else if (mem.ready) begin
          rdata_d = mem.rd;
          err_d   = 1'b0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        err_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  riscv_lsu_rd_fmt u_rd_fmt (
    .word   (rdata_q),
    .off    (off_q),
    .size   (size_q),
    .result (fmt_res)
  );

  always_comb begin
    core_stall_o = rst_ni && (((state_q == IDLE) && core_req_i) || (state_q == BUSY));
    mem.req      = rst_ni && (((state_q == IDLE) && core_req_i && !acc_err) ||
                              ((state_q == BUSY) && !timeout_hit));
    mem.we       = core_we_i && mem.req;
    mem.be       = mem.req ? lsu_be(core_size_i, core_addr_i[1:0]) : '0;
    mem.addr     = core_addr_i;
    mem.wd       = lsu_wd(core_size_i, core_wd_i);
    core_err_o   = err_q;
    core_rd_o    = ((state_q == DONE) && !err_q && !we_q) ? fmt_res : '0;
  end

endmodule

// File: tb/tb_riscv_lsu.sv
// Directed self-checking bench for riscv_lsu with hand-computed expectations.
module tb_riscv_lsu;
  import riscv_lsu_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        core_req;
  logic        core_we;
  logic [2:0]  core_size;
  logic [31:0] core_addr;
  logic [31:0] core_wd;
  logic [31:0] core_rd, core_rd_nt;
  logic        core_stall, core_stall_nt;
  logic        core_err, core_err_nt;
  logic [31:0] mem_rd;
  logic        mem_ready;

  int checks   = 0;
  int failures = 0;

  riscv_lsu_if bus ();
  riscv_lsu_if bus_nt ();

  assign bus.rd       = mem_rd;
  assign bus.ready    = mem_ready;
  assign bus_nt.rd    = mem_rd;
  assign bus_nt.ready = mem_ready;

  riscv_lsu #(.TIMEOUT_CYCLES(4)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .core_req_i(core_req), .core_we_i(core_we), .core_size_i(core_size),
    .core_addr_i(core_addr), .core_wd_i(core_wd),
    .core_rd_o(core_rd), .core_stall_o(core_stall), .core_err_o(core_err),
    .mem(bus.master)
  );

  riscv_lsu #(.TIMEOUT_CYCLES(0)) dut_nt (
    .clk_i(clk), .rst_ni(rst_n),
    .core_req_i(core_req), .core_we_i(core_we), .core_size_i(core_size),
    .core_addr_i(core_addr), .core_wd_i(core_wd),
    .core_rd_o(core_rd_nt), .core_stall_o(core_stall_nt), .core_err_o(core_err_nt),
    .mem(bus_nt.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // One core access; memory raises ready in cycle index 'waits' (counted from the request cycle).
  task automatic do_access(input logic we, input logic [2:0] size, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [31:0] rdata, input int waits,
                           output int stalls, output int reqs, output logic [3:0] be,
                           output logic [31:0] mwd, output logic [31:0] maddr,
                           output logic [31:0] rd, output logic err, output logic done);
    @(posedge clk); #1;
    core_req = 1'b1; core_we = we; core_size = size; core_addr = addr; core_wd = wd;
    mem_rd = rdata;
    stalls = 0; reqs = 0; be = '0; mwd = '0; maddr = '0; rd = '0; err = 1'b0; done = 1'b0;
    for (int k = 0; k < 60 && !done; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      mem_ready = (k == waits);
      @(negedge clk);
      if (core_stall) stalls++;
      if (bus.req) begin
        if (reqs == 0) begin be = bus.be; mwd = bus.wd; maddr = bus.addr; end
        reqs++;
      end
      if (!core_stall) begin
        done = 1'b1; rd = core_rd; err = core_err;
      end
    end
    @(posedge clk); #1;
    core_req = 1'b0; mem_ready = 1'b0;
  endtask

  int          stalls, reqs;
  logic [3:0]  be;
  logic [31:0] mwd, maddr, rd;
  logic        err, done;

  initial begin
    rst_n = 1'b0; core_req = 1'b0; core_we = 1'b0; core_size = '0;
    core_addr = '0; core_wd = '0; mem_rd = '0; mem_ready = 1'b0;
    #1 core_req = 1'b1; core_addr = 32'h100; core_size = LDST_W;
    #2;
    check_eq("rst_stall", 32'(core_stall), 32'd0);
    check_eq("rst_req", 32'(bus.req), 32'd0);
    check_eq("rst_rd", core_rd, 32'd0);
    check_eq("rst_err", 32'(core_err), 32'd0);
    core_req = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // SW, zero-wait memory
    do_access(1'b1, LDST_W, 32'h100, 32'hDEADBEEF, 32'h0, 0, stalls, reqs, be, mwd, maddr, rd, err, done);
    check_eq("sw_done", 32'(done), 32'd1);
    check_eq("sw_be", 32'(be), 32'hF);
    check_eq("sw_wd", mwd, 32'hDEADBEEF);
    check_eq("sw_addr", maddr, 32'h100);
    check_eq("sw_stalls", 32'(stalls), 32'd1);
    check_eq("sw_err", 32'(err), 32'd0);
    check_eq("sw_rd", rd, 32'd0);

    // LB / LBU with 3 wait cycles
    do_access(1'b0, LDST_B, 32'h103, 32'h0, 32'h80FF_0000, 3, stalls, reqs, be, mwd, maddr, rd, err, done);
    check_eq("lb_stalls", 32'(stalls), 32'd4);
    check_eq("lb_reqs", 32'(reqs), 32'd4);
    check_eq("lb_be", 32'(be), 32'h8);
    check_eq("lb_rd", rd, 32'hFFFFFF80);
    do_access(1'b0, LDST_BU, 32'h103, 32'h0, 32'h80FF_0000, 3, stalls, reqs, be, mwd, maddr, rd, err, done);
    check_eq("lbu_stalls", 32'(stalls), 32'd4);
    check_eq("lbu_rd", rd, 32'h00000080);

    // Halfword store/load and a byte store on lane 1
    do_access(1'b1, LDST_H, 32'h202, 32'h0000_1234, 32'h0, 0, stalls, reqs, be, mwd, maddr, rd, err, done);
    check_eq("sh_be", 32'(be), 32'hC);
    check_eq("sh_wd", mwd, 32'h12341234);
    do_access(1'b0, LDST_HU, 32'h202, 32'h0, 32'hA5A5_0000, 1, stalls, reqs, be, mwd, maddr, rd, err, done);
    check_eq("lhu_be", 32'(be), 32'hC);
    check_eq("lhu_rd", rd, 32'h0000A5A5);
    do_access(1'b0, LDST_H, 32'h200, 32'h0, 32'h1234_8001, 0, stalls, reqs, be, mwd, maddr, rd, err, done);
    check_eq("lh_be", 32'(be), 32'h3);
    check_eq("lh_rd", rd, 32'hFFFF8001);
    do_access(1'b1, LDST_B, 32'h101, 32'h0000_00AB, 32'h0, 0, stalls, reqs, be, mwd, maddr, rd, err, done);
    check_eq("sb_be", 32'(be), 32'h2);
    check_eq("sb_wd", mwd, 32'hABABABAB);
    do_access(1'b0, LDST_W, 32'h104, 32'h0, 32'h1234_5678, 2, stalls, reqs, be, mwd, maddr, rd, err, done);
    check_eq("lw_stalls", 32'(stalls), 32'd3);
    check_eq("lw_rd", rd, 32'h12345678);

    // Misaligned and illegal accesses never reach memory
    do_access(1'b0, LDST_W, 32'h101, 32'h0, 32'hFFFF_FFFF, 0, stalls, reqs, be, mwd, maddr, rd, err, done);
    check_eq("mis_w_reqs", 32'(reqs), 32'd0);
    check_eq("mis_w_err", 32'(err), 32'd1);
    check_eq("mis_w_rd", rd, 32'd0);
    check_eq("mis_w_stalls", 32'(stalls), 32'd1);
    do_access(1'b0, 3'd3, 32'h100, 32'h0, 32'hFFFF_FFFF, 0, stalls, reqs, be, mwd, maddr, rd, err, done);
    check_eq("ill_sz3_reqs", 32'(reqs), 32'd0);
    check_eq("ill_sz3_err", 32'(err), 32'd1);
    check_eq("ill_sz3_rd", rd, 32'd0);
    do_access(1'b1, LDST_BU, 32'h100, 32'h0, 32'h0, 0, stalls, reqs, be, mwd, maddr, rd, err, done);
    check_eq("ill_sbu_err", 32'(err), 32'd1);
    do_access(1'b0, LDST_HU, 32'h203, 32'h0, 32'hFFFF_FFFF, 0, stalls, reqs, be, mwd, maddr, rd, err, done);
    check_eq("mis_hu_err", 32'(err), 32'd1);
    // Error flag clears for the next good access
    do_access(1'b0, LDST_BU, 32'h102, 32'h0, 32'h0055_0000, 0, stalls, reqs, be, mwd, maddr, rd, err, done);
    check_eq("post_err_err", 32'(err), 32'd0);
    check_eq("post_err_rd", rd, 32'h00000055);

    // Timeout after 4 request cycles
    do_access(1'b0, LDST_W, 32'h300, 32'h0, 32'h1111_1111, 99, stalls, reqs, be, mwd, maddr, rd, err, done);
    check_eq("to_reqs", 32'(reqs), 32'd4);
    check_eq("to_stalls", 32'(stalls), 32'd5);
    check_eq("to_err", 32'(err), 32'd1);
    check_eq("to_rd", rd, 32'd0);

    // Timeout disabled: keeps waiting, then completes
    @(posedge clk); #1;
    core_req = 1'b1; core_we = 1'b0; core_size = LDST_W; core_addr = 32'h400; mem_rd = 32'hCAFE_F00D;
    repeat (20) @(posedge clk);
    @(negedge clk);
    check_eq("nt_stall", 32'(core_stall_nt), 32'd1);
    check_eq("nt_req", 32'(bus_nt.req), 32'd1);
    @(posedge clk); #1 mem_ready = 1'b1;
    @(posedge clk); #1 mem_ready = 1'b0;
    @(negedge clk);
    check_eq("nt_done_stall", 32'(core_stall_nt), 32'd0);
    check_eq("nt_done_rd", core_rd_nt, 32'hCAFEF00D);
    check_eq("nt_done_err", 32'(core_err_nt), 32'd0);
    @(posedge clk); #1 core_req = 1'b0;

    // Reset in BUSY drops request and stall immediately
    repeat (8) @(posedge clk);
    #1 core_req = 1'b1; core_size = LDST_W; core_addr = 32'h500;
    repeat (2) @(posedge clk);
    #1;
    check_eq("pre_rst_req", 32'(bus.req), 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_req", 32'(bus.req), 32'd0);
    check_eq("mid_rst_stall", 32'(core_stall), 32'd0);
    core_req = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    do_access(1'b0, LDST_W, 32'h504, 32'h0, 32'h0BAD_CAFE, 0, stalls, reqs, be, mwd, maddr, rd, err, done);
    check_eq("post_rst_stalls", 32'(stalls), 32'd1);
    check_eq("post_rst_rd", rd, 32'h0BADCAFE);
    check_eq("post_rst_err", 32'(err), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/riscv_lsu.md
Name: riscv_lsu

Overview:
Load-store unit between the core's data-memory port and a variable-latency data memory.
- Sequences each core load or store into one handshaked memory transaction.
- Holds the core via core_stall_o until the transaction completes.
- Generates byte enables, replicates store data and sign/zero-extends load data.
- Flags misaligned, illegal-size and timed-out accesses.

Parameters:
TIMEOUT_CYCLES, 16, max cycles in BUSY without mem_ready_i before abort; 0 disables timeout.

Ports:
clk_i  input  1  clock
rst_ni  input  1  reset, asynchronous, active-low
core_req_i  input  1  core requests a memory access; held stable with all core_* inputs while core_stall_o=1
core_we_i  input  1  1=store, 0=load
core_size_i  input  3  RV32 funct3: 0 B, 1 H, 2 W, 4 BU, 5 HU
core_addr_i  input  32  byte address
core_wd_i  input  32  store data (low bits significant)
core_rd_o  output  32  formatted load data, valid in DONE
core_stall_o  output  1  core must hold PC and inputs
core_err_o  output  1  access aborted (misaligned, illegal size, timeout); valid in DONE
mem_req_o  output  1  memory request
mem_we_o  output  1  memory write
mem_be_o  output  4  byte enables
mem_addr_o  output  32  equals core_addr_i
mem_wd_o  output  32  replicated store data
mem_rd_i  input  32  read word, valid when mem_ready_i=1
mem_ready_i  input  1  memory completes the current request this cycle

Behaviour:
- Reset: all outputs 0, state IDLE, timeout counter 0, rdata register 0, err flag 0. mem_req_o and core_stall_o are forced 0 combinationally while rst_ni=0. Reset mid-transaction abandons the access; the memory must tolerate a dropped request.
- States: IDLE, BUSY, DONE.
- Error check (combinational, on core inputs):
  - Illegal: core_size_i in {3,6,7}; stores with size 4 or 5.
  - Misaligned: H/HU with addr[0]=1; W with addr[1:0]≠0.
- IDLE:
  - core_req_i=0: no outputs active.
  - core_req_i=1 and error: core_stall_o=1, mem_req_o=0, latch err=1, go to DONE.
  - core_req_i=1, no error: core_stall_o=1, mem_req_o=1.
    - mem_ready_i=1: latch mem_rd_i, go to DONE.
    - Otherwise: go to BUSY, counter=1.
- BUSY:
  - core_stall_o=1, mem_req_o=1.
  - mem_ready_i=1: latch mem_rd_i, err=0, go to DONE.
  - Counter reaches TIMEOUT_CYCLES (TIMEOUT_CYCLES≠0) without ready: mem_req_o=0 in that cycle, err=1, go to DONE.
  - Otherwise increment the counter.
- DONE:
  - core_stall_o=0, mem_req_o=0. core_rd_o and core_err_o are driven from latched state.
  - core_req_i is ignored, since it belongs to the retiring instruction.
  - Next cycle: IDLE. err clears on leaving DONE.
- Latency: 0-wait memory gives 1 stall cycle plus the DONE cycle; N wait cycles give N+1 stall cycles. Back-to-back accesses pass through IDLE each time.
- mem_we_o = core_we_i & mem_req_o.
- mem_be_o (0 when mem_req_o=0):
  - B: 4'b0001<<addr[1:0]
  - H: 4'b0011<<{addr[1],1'b0}
  - W: 4'b1111
- mem_wd_o:
  - B: {4{wd[7:0]}}
  - H: {2{wd[15:0]}}
  - W: wd
- core_rd_o: select the byte/half of the latched word using the latched addr[1:0] and size.
  - B/H: sign-extend. BU/HU: zero-extend. W: the word as is.
  - Stores and errored accesses return 0.
- mem_ready_i outside IDLE-with-request or BUSY is ignored.

Decomposition:
- Package riscv_lsu_pkg:
  - Size constants LDST_B=3'd0, LDST_H=3'd1, LDST_W=3'd2, LDST_BU=3'd4, LDST_HU=3'd5.
  - State enum lsu_state_t {IDLE, BUSY, DONE}.
- One sub-module, riscv_lsu_rd_fmt: combinational load extraction (word, addr[1:0], size → 32-bit result). Unit-testable standalone.

Test Plan:
1. SW addr=0x100, wd=0xDEADBEEF, ready on first cycle → mem_be_o=4'hF, mem_wd_o=0xDEADBEEF, stall high for exactly 1 cycle, core_err_o=0.
2. LB addr=0x103, mem_rd_i=0x80FF_0000 with 3 wait cycles → stall 4 cycles, be=4'b1000, core_rd_o=0xFFFFFF80; repeat as LBU → 0x00000080.
3. SH addr=0x202, wd=0x0000_1234 → mem_be_o=4'b1100, mem_wd_o=0x12341234; LHU addr=0x202 with mem_rd_i=0xA5A5_0000 → core_rd_o=0x0000A5A5.
4. LW addr=0x101 → mem_req_o never asserted, DONE with core_err_o=1, core_rd_o=0; size=3 behaves identically.
5. TIMEOUT_CYCLES=4, LW with mem_ready_i held 0 → mem_req_o high 4 cycles, then DONE with core_err_o=1; TIMEOUT_CYCLES=0 → waits indefinitely.
6. rst_ni pulled low in BUSY → mem_req_o and core_stall_o drop to 0 immediately; after release, state IDLE and the next LW completes normally.
